// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Data-memory responder with wait states, byte/half/word lanes,
//            load extension and fault detection behind the MEM stage.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRequest,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemFault,
    output logic        Stall
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           wr_q;
    logic [2:0]     f3_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic           ready_q;
    logic           fault_q;
    logic [31:0]    rdata_q;
    logic [31:0]    mem_q [DEPTH_WORDS];

    logic           acc_wr;
    logic [2:0]     acc_f3;
    logic [31:0]    acc_addr;
    logic [31:0]    acc_wdata;
    logic           enter_resp;
    logic           fault_d;
    logic [31:0]    rdata_d;
    logic [AW-1:0]  idx;
    logic [31:0]    rd_shift;
    logic [31:0]    load_val;
    logic [3:0]     be;
    logic [31:0]    wd_lanes;
    logic           bad_f3;

    // With zero wait states the access completes on the capture edge, so the
    // live inputs stand in for the not-yet-captured registers while in IDLE.
    always_comb begin
        acc_wr    = (state_q == S_IDLE) ? MemWrite   : wr_q;
        acc_f3    = (state_q == S_IDLE) ? Funct3     : f3_q;
        acc_addr  = (state_q == S_IDLE) ? Addr       : addr_q;
        acc_wdata = (state_q == S_IDLE) ? WriteData  : wdata_q;
    end

    assign enter_resp = ((state_q == S_IDLE) && MemRequest && (WAIT_CYCLES == 0)) ||
                        ((state_q == S_WAIT) && (cnt_q == CW'(1)));

    assign idx = acc_addr[AW+1:2];

    always_comb begin
        bad_f3 = 1'b0;
        case (acc_f3)
            3'b000, 3'b100: bad_f3 = acc_wr && acc_f3[2];
            3'b001, 3'b101: bad_f3 = acc_addr[0] || (acc_wr && acc_f3[2]);
            3'b010:         bad_f3 = (acc_addr[1:0] != 2'b00);
            default:        bad_f3 = 1'b1;
        endcase
        fault_d = bad_f3 || ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
    end

    always_comb begin
        rd_shift = mem_q[idx] >> {acc_addr[1:0], 3'b000};
        case (acc_f3)
            3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  load_val = {24'h0, rd_shift[7:0]};
            3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  load_val = {16'h0, rd_shift[15:0]};
            default: load_val = rd_shift;
        endcase
        rdata_d = (fault_d || acc_wr) ? 32'h0 : load_val;
    end

    always_comb begin
        case (acc_f3[1:0])
            2'b00: begin
                be       = 4'b0001 << acc_addr[1:0];
                wd_lanes = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                be       = acc_addr[1] ? 4'b1100 : 4'b0011;
                wd_lanes = {2{acc_wdata[15:0]}};
            end
            default: begin
                be       = 4'b1111;
                wd_lanes = acc_wdata;
            end
        endcase
    end

    // Reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (enter_resp && !reset && acc_wr && !fault_d) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wd_lanes[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            if (enter_resp) begin
                ready_q <= 1'b1;
                fault_q <= fault_d;
                rdata_q <= rdata_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (MemRequest) begin
                        wr_q    <= MemWrite;
                        f3_q    <= Funct3;
                        addr_q  <= Addr;
                        wdata_q <= WriteData;
                        cnt_q   <= CW'(WAIT_CYCLES);
                        state_q <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ReadData = rdata_q;
    assign MemReady = ready_q;
    assign MemFault = fault_q;
    assign Stall    = (state_q == S_WAIT) || ((state_q == S_IDLE) && MemRequest);

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed scoreboard bench for dmem_responder (2 and 0 wait states).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    typedef struct {
        logic        fault;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, wr0, req1, wr1;
    logic [2:0]  f30, f31;
    logic [31:0] a0, wd0, a1, wd1;
    logic [31:0] rd0, rd1;
    logic        rdy0, flt0, stl0, rdy1, flt1, stl1;

    int compares = 0;
    int fails    = 0;
    int pulses0  = 0;
    int pulses1  = 0;
    int issued0  = 0;
    int issued1  = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .MemRequest(req0), .MemWrite(wr0), .Funct3(f30),
        .Addr(a0), .WriteData(wd0), .ReadData(rd0), .MemReady(rdy0),
        .MemFault(flt0), .Stall(stl0)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset(reset), .MemRequest(req1), .MemWrite(wr1), .Funct3(f31),
        .Addr(a1), .WriteData(wd1), .ReadData(rd1), .MemReady(rdy1),
        .MemFault(flt1), .Stall(stl1)
    );

    always @(negedge clk) begin
        if (rdy0 === 1'b1) pulses0++;
        if (rdy1 === 1'b1) pulses1++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic rq, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        if (sel == 0) begin
            req0 = rq; wr0 = wr; f30 = f3; a0 = a; wd0 = wd;
        end else begin
            req1 = rq; wr1 = wr; f31 = f3; a1 = a; wd1 = wd;
        end
    endtask

    task automatic access(input int sel, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic ef, input logic [31:0] ed, input int lat,
                          input bit hold, input string tag);
        exp_t e;
        int   c;
        bit   done;
        e.fault = ef;
        e.data  = ed;
        sb_q.push_back(e);
        if (sel == 0) issued0++; else issued1++;
        @(posedge clk); #1;
        drive(sel, 1'b1, wr, f3, a, wd);
        c    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (((sel == 0) ? rdy0 : rdy1) === 1'b1) begin
                e = sb_q.pop_front();
                check({tag, ":latency"}, 32'(c), 32'(lat));
                check({tag, ":rdata"}, (sel == 0) ? rd0 : rd1, e.data);
                check({tag, ":fault"}, {31'h0, (sel == 0) ? flt0 : flt1}, {31'h0, e.fault});
                check({tag, ":stall_resp"}, {31'h0, (sel == 0) ? stl0 : stl1}, 32'h0);
                if (!hold) drive(sel, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
                done = 1'b1;
            end else begin
                check({tag, ":stall_wait"}, {31'h0, (sel == 0) ? stl0 : stl1}, 32'h1);
                c++;
                if (c > 20) begin
                    fails++;
                    $display("FAIL %s:timeout observed=no_ready expected=ready", tag);
                    void'(sb_q.pop_front());
                    drive(sel, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
                    done = 1'b1;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst:ready", {31'h0, rdy0}, 32'h0);
        check("rst:fault", {31'h0, flt0}, 32'h0);
        check("rst:stall", {31'h0, stl0}, 32'h0);
        check("rst:rdata", rd0, 32'h0);
        check("rst:w0_ready", {31'h0, rdy1}, 32'h0);
        reset = 1'b0;

        // Basic store and extended loads
        access(0, 1'b1, F_W,  32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        3, 1'b0, "sw10");
        access(0, 1'b0, F_B,  32'h13, 32'h0,        1'b0, 32'hFFFFFFDE, 3, 1'b0, "lb13");
        access(0, 1'b0, F_BU, 32'h13, 32'h0,        1'b0, 32'h000000DE, 3, 1'b0, "lbu13");
        access(0, 1'b0, F_HU, 32'h12, 32'h0,        1'b0, 32'h0000DEAD, 3, 1'b0, "lhu12");
        access(0, 1'b0, F_H,  32'h10, 32'h0,        1'b0, 32'hFFFFBEEF, 3, 1'b0, "lh10");

        // Lane preservation
        access(0, 1'b1, F_B,  32'h11, 32'h00000055, 1'b0, 32'h0,        3, 1'b0, "sb11");
        access(0, 1'b0, F_W,  32'h10, 32'h0,        1'b0, 32'hDEAD55EF, 3, 1'b0, "lw10");
        @(negedge clk);
        check("hold:rdata", rd0, 32'hDEAD55EF);
        check("hold:ready", {31'h0, rdy0}, 32'h0);
        check("hold:fault", {31'h0, flt0}, 32'h0);
        access(0, 1'b1, F_W,  32'h18, 32'h0,        1'b0, 32'h0,        3, 1'b0, "sw18");
        access(0, 1'b1, F_H,  32'h1A, 32'hFFFFA5A5, 1'b0, 32'h0,        3, 1'b0, "sh1a");
        access(0, 1'b0, F_W,  32'h18, 32'h0,        1'b0, 32'hA5A50000, 3, 1'b0, "lw18");
        access(0, 1'b0, F_H,  32'h1A, 32'h0,        1'b0, 32'hFFFFA5A5, 3, 1'b0, "lh1a");

        // Faults
        access(0, 1'b1, F_W,  32'h0,    32'h11112222, 1'b0, 32'h0, 3, 1'b0, "sw0");
        access(0, 1'b0, F_W,  32'h12,   32'h0,        1'b1, 32'h0, 3, 1'b0, "lw_mis");
        access(0, 1'b1, F_W,  32'h1000, 32'hFFFFFFFF, 1'b1, 32'h0, 3, 1'b0, "sw_oob");
        access(0, 1'b0, 3'b011, 32'h0,  32'h0,        1'b1, 32'h0, 3, 1'b0, "ld_f3_011");
        access(0, 1'b1, F_BU, 32'h0,    32'hFFFFFFFF, 1'b1, 32'h0, 3, 1'b0, "st_f3_100");
        access(0, 1'b0, F_H,  32'h11,   32'h0,        1'b1, 32'h0, 3, 1'b0, "lh_mis");
        access(0, 1'b0, F_W,  32'h0,    32'h0,        1'b0, 32'h11112222, 3, 1'b0, "lw0");

        // Back-to-back with request held through RESP
        access(0, 1'b0, F_W,  32'h10, 32'h0,        1'b0, 32'hDEAD55EF, 3, 1'b1, "b2b_lw");
        access(0, 1'b1, F_W,  32'h30, 32'h0F0F0F0F, 1'b0, 32'h0,        3, 1'b0, "b2b_sw");
        access(0, 1'b0, F_W,  32'h30, 32'h0,        1'b0, 32'h0F0F0F0F, 3, 1'b0, "lw30");

        // Reset during WAIT aborts the store
        access(0, 1'b1, F_W,  32'h20, 32'hCAFEF00D, 1'b0, 32'h0, 3, 1'b0, "sw20");
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, F_W, 32'h20, 32'h12345678);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        check("abort1:stall", {31'h0, stl0}, 32'h0);
        check("abort1:ready", {31'h0, rdy0}, 32'h0);
        check("abort1:rdata", rd0, 32'h0);
        reset = 1'b0;
        access(0, 1'b0, F_W,  32'h20, 32'h0, 1'b0, 32'hCAFEF00D, 3, 1'b0, "lw20");

        // Reset coinciding with the edge entering RESP
        access(0, 1'b1, F_W,  32'h24, 32'h77777777, 1'b0, 32'h0, 3, 1'b0, "sw24");
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, F_W, 32'h24, 32'h88888888);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        check("abort2:ready", {31'h0, rdy0}, 32'h0);
        check("abort2:stall", {31'h0, stl0}, 32'h0);
        reset = 1'b0;
        access(0, 1'b0, F_W,  32'h24, 32'h0, 1'b0, 32'h77777777, 3, 1'b0, "lw24");

        // Zero wait states
        access(1, 1'b1, F_W,  32'h40, 32'h0BADCAFE, 1'b0, 32'h0,        1, 1'b0, "w0_sw40");
        access(1, 1'b0, F_W,  32'h40, 32'h0,        1'b0, 32'h0BADCAFE, 1, 1'b0, "w0_lw40");
        access(1, 1'b0, F_BU, 32'h41, 32'h0,        1'b0, 32'h000000CA, 1, 1'b0, "w0_lbu41");
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, F_W, 32'h40, 32'h00000099);
        reset = 1'b1;
        @(negedge clk);
        check("w0_abort:ready", {31'h0, rdy1}, 32'h0);
        drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        reset = 1'b0;
        access(1, 1'b0, F_W,  32'h40, 32'h0, 1'b0, 32'h0BADCAFE, 1, 1'b0, "w0_lw40b");

        repeat (5) @(negedge clk);
        check("pulses0", 32'(pulses0), 32'(issued0));
        check("pulses1", 32'(pulses1), 32'(issued1));
        check("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
`default_nettype wire
